// File: rtl/approx_accum_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// approx_accum_pkg : shared types, defaults and helpers for approx_accum_lanes
// Rev 1.0
// ----------------------------------------------------------------------------
package approx_accum_pkg;

   localparam int DEF_DW    = 20;
   localparam int DEF_CH    = 4;
   localparam int DEF_MAX_K = 8;
   localparam int DEF_KW    = 4;
   localparam int DEF_LW    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   function automatic int clamp_k(input int k, input int max_k);
      return (k > max_k) ? max_k : k;
   endfunction

endpackage
`default_nettype wire

// File: rtl/approx_accum_lanes_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// approx_accum_lanes_if : config, input-stream and output-stream bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface approx_accum_lanes_if
   import approx_accum_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int CH = DEF_CH,
   parameter int KW = DEF_KW,
   parameter int LW = DEF_LW
) ();
   logic              cfg_approx_en;
   logic [KW-1:0]     cfg_k;
   logic [LW-1:0]     cfg_len;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CH*DW-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CH*DW-1:0]  out_data;

   modport master (
      output cfg_approx_en, cfg_k, cfg_len, flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  cfg_approx_en, cfg_k, cfg_len, flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/approx_add_var.sv
`default_nettype none
// ----------------------------------------------------------------------------
// approx_add_var : DW-bit lower-part-OR adder with runtime k / exact fallback
// Rev 1.0
// ----------------------------------------------------------------------------
module approx_add_var #(
   parameter int DW = 20,
   parameter int KW = 4
) (
   input  wire logic [DW-1:0] a_i,
   input  wire logic [DW-1:0] b_i,
   input  wire logic          approx_en_i,
   input  wire logic [KW-1:0] k_i,
   output      logic [DW-1:0] sum_o
);
   logic [KW-1:0] w_k;
   logic [DW-1:0] w_lo_mask;
   logic [DW-1:0] w_top;
   logic          w_carry;
   logic [DW-1:0] w_cin;

   // k = 0 yields an empty low mask, so the exact add falls out of the same path
   assign w_k       = approx_en_i ? k_i : '0;
   assign w_lo_mask = ~({DW{1'b1}} << w_k);
   assign w_top     = w_lo_mask ^ (w_lo_mask >> 1);
   assign w_carry   = |(a_i & b_i & w_top);
   assign w_cin     = w_carry ? (w_top << 1) : '0;

   assign sum_o = ((a_i & ~w_lo_mask) + (b_i & ~w_lo_mask) + w_cin)
                | ((a_i | b_i) & w_lo_mask);
endmodule
`default_nettype wire

// File: rtl/approx_accum_lanes.sv
`default_nettype none
// ----------------------------------------------------------------------------
// approx_accum_lanes : CH-lane windowed partial-sum accumulator, approx or exact
// Rev 1.0
// ----------------------------------------------------------------------------
module approx_accum_lanes
   import approx_accum_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int CH    = DEF_CH,
   parameter int MAX_K = DEF_MAX_K,
   parameter int KW    = DEF_KW,
   parameter int LW    = DEF_LW
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   approx_accum_lanes_if.slave bus_io
);
   state_t            state_q;
   logic [LW-1:0]     cnt_q;
   logic [LW-1:0]     len_q;
   logic              approx_q;
   logic [KW-1:0]     k_q;
   logic [DW-1:0]     acc_q [CH];
   logic [CH*DW-1:0]  out_data_q;
   logic              out_valid_q;
   logic              in_ready_q;

   logic [DW-1:0]     w_sum [CH];
   logic [KW-1:0]     w_k_clamp;
   logic [LW-1:0]     w_len_eff;
   logic              w_accept;

   assign w_k_clamp = KW'(clamp_k(int'(bus_io.cfg_k), MAX_K));
   assign w_len_eff = (bus_io.cfg_len == '0) ? LW'(1) : bus_io.cfg_len;
   assign w_accept  = bus_io.in_valid && in_ready_q;

   generate
      for (genvar j = 0; j < CH; j++) begin : g_lane
         approx_add_var #(.DW(DW), .KW(KW)) u_add (
            .a_i         (acc_q[j]),
            .b_i         (bus_io.in_data[j*DW +: DW]),
            .approx_en_i (approx_q),
            .k_i         (k_q),
            .sum_o       (w_sum[j])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         approx_q    <= 1'b0;
         k_q         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         for (int j = 0; j < CH; j++) acc_q[j] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               // first sample loads directly and fixes the window's config
               if (!bus_io.flush && w_accept) begin
                  for (int j = 0; j < CH; j++) acc_q[j] <= bus_io.in_data[j*DW +: DW];
                  cnt_q    <= LW'(1);
                  approx_q <= bus_io.cfg_approx_en;
                  k_q      <= w_k_clamp;
                  len_q    <= w_len_eff;
                  if (w_len_eff == LW'(1)) begin
                     out_data_q  <= bus_io.in_data;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     state_q     <= OUT;
                  end else begin
                     state_q <= ACC;
                  end
               end
            end
            ACC: begin
               if (bus_io.flush) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (w_accept) begin
                  for (int j = 0; j < CH; j++) acc_q[j] <= w_sum[j];
                  cnt_q <= cnt_q + LW'(1);
                  if (cnt_q == len_q - LW'(1)) begin
                     for (int j = 0; j < CH; j++) out_data_q[j*DW +: DW] <= w_sum[j];
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     state_q     <= OUT;
                  end
               end
            end
            OUT: begin
               if (bus_io.out_ready) begin
                  out_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus_io.in_ready  = in_ready_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_data  = out_data_q;
endmodule
`default_nettype wire

// File: tb/tb_approx_accum_lanes.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_approx_accum_lanes : directed vector bench for approx_accum_lanes
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_approx_accum_lanes;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   approx_accum_lanes_if #(.DW(20), .CH(4), .KW(4), .LW(8)) bus ();

   approx_accum_lanes #(.DW(20), .CH(4), .MAX_K(8), .KW(4), .LW(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus.slave)
   );

   typedef struct {
      logic             ap;
      logic [3:0]       k;
      logic [7:0]       len;
      int               n;
      logic [3:0][19:0] s;
      logic [19:0]      exp;
   } vec_t;

   vec_t tbl [9];

   function automatic vec_t mk(input logic ap, input logic [3:0] k, input logic [7:0] len,
                               input int n, input logic [19:0] s0, input logic [19:0] s1,
                               input logic [19:0] s2, input logic [19:0] s3,
                               input logic [19:0] exp);
      vec_t v;
      v.ap = ap; v.k = k; v.len = len; v.n = n;
      v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
      v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [79:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic set_cfg(input logic ap, input logic [3:0] k, input logic [7:0] len);
      bus.cfg_approx_en = ap;
      bus.cfg_k         = k;
      bus.cfg_len       = len;
   endtask

   task automatic drain(input logic [79:0] exp);
      chk("out_valid", {79'd0, bus.out_valid}, 80'd1);
      chk("out_data", bus.out_data, exp);
      chk("in_ready_out", {79'd0, bus.in_ready}, 80'd0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("valid_drop", {79'd0, bus.out_valid}, 80'd0);
      chk("ready_back", {79'd0, bus.in_ready}, 80'd1);
   endtask

   task automatic run_win(input logic ap, input logic [3:0] k, input logic [7:0] len,
                          input int n, input logic [3:0][79:0] d, input logic [79:0] exp);
      set_cfg(ap, k, len);
      for (int i = 0; i < n; i++) begin
         chk("in_ready_acc", {79'd0, bus.in_ready}, 80'd1);
         send(d[i]);
         if (i < n - 1) chk("no_early_valid", {79'd0, bus.out_valid}, 80'd0);
      end
      drain(exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0][79:0] d;

      tbl[0] = mk(1'b0, 4'd0,  8'd3, 3, 20'h00005, 20'h00007, 20'h00009, 20'h0, 20'h00015);
      tbl[1] = mk(1'b1, 4'd4,  8'd3, 3, 20'h00008, 20'h00008, 20'h00008, 20'h0, 20'h00028);
      tbl[2] = mk(1'b1, 4'd4,  8'd2, 2, 20'h0000F, 20'h00001, 20'h0,     20'h0, 20'h0000F);
      tbl[3] = mk(1'b0, 4'd0,  8'd2, 2, 20'hFFFFF, 20'h00001, 20'h0,     20'h0, 20'h00000);
      tbl[4] = mk(1'b0, 4'd0,  8'd0, 1, 20'h12345, 20'h0,     20'h0,     20'h0, 20'h12345);
      tbl[5] = mk(1'b1, 4'd15, 8'd2, 2, 20'h000FF, 20'h00080, 20'h0,     20'h0, 20'h001FF);
      tbl[6] = mk(1'b1, 4'd0,  8'd2, 2, 20'h00008, 20'h00008, 20'h0,     20'h0, 20'h00010);
      tbl[7] = mk(1'b1, 4'd8,  8'd4, 4, 20'h00100, 20'h00100, 20'h00001, 20'h00003, 20'h00203);
      tbl[8] = mk(1'b0, 4'd0,  8'd4, 4, 20'h80000, 20'h80000, 20'h00003, 20'h00004, 20'h00007);

      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.out_ready = 1'b0;
      bus.flush    = 1'b0;
      set_cfg(1'b0, 4'd0, 8'd1);

      // reset state
      #2 rst_n = 1'b0;
      #4;
      chk("rst_out_valid", {79'd0, bus.out_valid}, 80'd0);
      chk("rst_in_ready", {79'd0, bus.in_ready}, 80'd0);
      chk("rst_out_data", bus.out_data, 80'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ready_after_rst", {79'd0, bus.in_ready}, 80'd1);

      // distinct lane values check the lane packing
      d[0] = {20'h00004, 20'h00003, 20'h00002, 20'h00001};
      d[1] = {20'h00040, 20'h00030, 20'h00020, 20'h00010};
      d[2] = '0; d[3] = '0;
      run_win(1'b0, 4'd0, 8'd2, 2, d, {20'h00044, 20'h00033, 20'h00022, 20'h00011});

      for (int v = 0; v < 9; v++) begin
         for (int i = 0; i < 4; i++) d[i] = {4{tbl[v].s[i]}};
         run_win(tbl[v].ap, tbl[v].k, tbl[v].len, tbl[v].n, d, {4{tbl[v].exp}});
      end

      // backpressure: result held, inputs and flush ignored while in OUT
      set_cfg(1'b0, 4'd0, 8'd1);
      send({4{20'hABCDE}});
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = {4{20'h55555}};
         bus.flush    = (i == 2);
         chk("bp_valid", {79'd0, bus.out_valid}, 80'd1);
         chk("bp_data", bus.out_data, {4{20'hABCDE}});
         chk("bp_in_ready", {79'd0, bus.in_ready}, 80'd0);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      drain({4{20'hABCDE}});
      d[0] = {4{20'h11111}};
      run_win(1'b0, 4'd0, 8'd1, 1, d, {4{20'h11111}});

      // mid-window config change has no effect
      set_cfg(1'b1, 4'd4, 8'd3);
      send({4{20'h00008}});
      set_cfg(1'b0, 4'd0, 8'd2);
      send({4{20'h00008}});
      chk("cfg_hold_len", {79'd0, bus.out_valid}, 80'd0);
      send({4{20'h00008}});
      drain({4{20'h00028}});

      // flush after 2 of 4 samples, with a sample presented alongside
      set_cfg(1'b0, 4'd0, 8'd4);
      send({4{20'h00100}});
      send({4{20'h00200}});
      bus.in_valid = 1'b1;
      bus.in_data  = {4{20'h00999}};
      bus.flush    = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      chk("flush_no_valid", {79'd0, bus.out_valid}, 80'd0);
      chk("flush_ready", {79'd0, bus.in_ready}, 80'd1);
      d[0] = {4{20'h00001}};
      d[1] = {4{20'h00002}};
      run_win(1'b0, 4'd0, 8'd2, 2, d, {4{20'h00003}});

      // asynchronous reset mid-window
      set_cfg(1'b0, 4'd0, 8'd4);
      send({4{20'h00005}});
      send({4{20'h00006}});
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {79'd0, bus.out_valid}, 80'd0);
      chk("arst_in_ready", {79'd0, bus.in_ready}, 80'd0);
      chk("arst_out_data", bus.out_data, 80'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      d[0] = {4{20'h00007}};
      d[1] = {4{20'h00008}};
      run_win(1'b0, 4'd0, 8'd2, 2, d, {4{20'h0000F}});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/approx_accum_lanes.md
Name: approx_accum_lanes

Overview:
- Multi-lane, parametrised approximate accumulator for CNN partial-sum reduction.
- Each lane sums cfg_len consecutive input samples using a runtime-configurable lower-part-OR approximate adder, or an exact adder when approximation is disabled.
- Sits between the multiplier array and the output/activation stage.
- Uses valid/ready handshakes on both sides and emits one CH-wide result per window.

Parameters:
- DW, 20: per-lane data and accumulator width in bits (unsigned, modulo 2^DW).
- CH, 4: number of parallel lanes sharing one handshake.
- MAX_K, 8: largest approximate low-part width; must satisfy 1 <= MAX_K < DW.
- KW, 4: width of cfg_k; must satisfy 2^KW > MAX_K.
- LW, 8: width of cfg_len and of the sample counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_approx_en  in  1  1 = approximate add, 0 = exact add.
- cfg_k  in  KW  approximate low-part width; values above MAX_K are clamped to MAX_K.
- cfg_len  in  LW  samples per window; 0 is treated as 1.
- flush  in  1  synchronous abort of the current window.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  CH*DW  lane j occupies bits [j*DW +: DW].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  CH*DW  per-lane window sums, same packing as in_data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, counter=0, all accumulators=0, out_data=0, out_valid=0, in_ready=0 while rst_n=0 and 1 after release.
- Accept: a sample is accepted in a cycle where in_valid && in_ready.
- Approximate add, op(a,b) with K = effective cfg_k and approximation enabled and K>0:
  - s[i] = a[i] | b[i] for i < K.
  - carry into bit K = a[K-1] & b[K-1].
  - bits K..DW-1 are an exact ripple sum with that carry-in.
  - The final carry-out is discarded (wrap).
- Exact add: when cfg_approx_en=0 or K=0, op is an exact modulo-2^DW add.
- Config latching: cfg_approx_en, cfg_k and cfg_len are latched on the first accepted sample of a window and held until the window ends. Mid-window changes have no effect.
- State IDLE: in_ready=1.
  - On accept: acc[j] <= in lane j (op with 0 is identity), counter <= 1.
  - If effective len == 1, go to OUT with out_data <= sample. Otherwise go to ACC.
- State ACC: in_ready=1.
  - On accept: acc[j] <= op(acc[j], lane j), counter++.
  - When the accepted sample is number len (counter == len-1 before the update), out_data <= op result, out_valid <= 1, go to OUT.
- State OUT: in_ready=0; out_valid=1 and out_data held stable until out_ready.
  - On out_ready: out_valid <= 0, counter <= 0, go to IDLE.
- Latency: out_valid rises on the cycle after the last sample is accepted.
- Throughput: at most one window result per len+1 cycles (one bubble cycle in OUT).
- flush: in IDLE or ACC, flush=1 discards the partial window and returns to IDLE. Any sample presented in the same cycle is dropped.
- flush in OUT is ignored: a completed result is never lost.
- Simultaneous events: in_valid and flush in the same cycle means flush wins.
- Reset mid-window: all state is cleared immediately and asynchronously; no partial output is produced.
- Overflow: accumulators wrap silently modulo 2^DW; no saturation and no flag.

Decomposition:
- Package approx_accum_pkg holds:
  - state encoding constants IDLE=2'd0, ACC=2'd1, OUT=2'd2;
  - default DW/MAX_K/LW constants;
  - a clamp helper for cfg_k.
- Sub-module approx_add_var: combinational DW-bit adder with runtime k and approx_en inputs, instantiated CH times.

Test Plan:
- Exact accumulate, all lanes: DW=20, approx_en=0, len=3, samples 5,7,9 -> out_data lanes = 0x00015, out_valid asserted 1 cycle after the 3rd accept.
- Approx carry case: approx_en=1, k=4, len=3, lane samples 0x8,0x8,0x8 -> 0x00028 (exact would be 0x18). Single add of 0xF+0x1 with len=2 -> 0x0000F.
- Wrap and len edge: exact, len=2, samples 0xFFFFF,0x00001 -> 0x00000. Separately, len=0 with sample 0x12345 -> out 0x12345 after 1 sample.
- Backpressure: hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout; on out_ready=1, IDLE next cycle and a new window is accepted.
- Config change mid-window: start with k=4 approx, switch to approx_en=0 after the 1st sample -> the result still matches k=4 approx.
- flush and reset: flush after 2 of 4 samples -> no out_valid, next window sums from 0. rst_n low mid-ACC -> out_valid=0 and all outputs 0 asynchronously.
